// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice: stage indices,
// stall bus width, redirect PC width and the redirect-request record.
package pipe_pkg;

  localparam int unsigned PC_IDX  = 0;
  localparam int unsigned IF_IDX  = 1;
  localparam int unsigned ID_IDX  = 2;
  localparam int unsigned EX_IDX  = 3;
  localparam int unsigned MEM_IDX = 4;
  localparam int unsigned WB_IDX  = 5;

  localparam int unsigned STALL_BUS_W = 6;
  localparam int unsigned PC_W        = 32;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
  } redirect_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline <-> controller signal bundle. The pipeline side (master) raises
// requests; the controller side (slave) returns stall/bubble/flush.
interface pipe_ctrl_if #(
  parameter int unsigned STAGES = pipe_pkg::STALL_BUS_W,
  parameter int unsigned PC_W   = pipe_pkg::PC_W
);

  logic [STAGES-1:0] stallreq;
  logic              load_use;
  logic              flush_req;
  logic [PC_W-1:0]   flush_pc;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] bubble;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic              busy;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output stallreq, load_use, flush_req, flush_pc,
    input  stall, bubble, flush, new_pc, busy, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  stallreq, load_use, flush_req, flush_pc,
    output stall, bubble, flush, new_pc, busy, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_ldu_timer.sv
// Load-use hold timer: a load restarts the down counter at LOAD_LAT-1,
// clr wins over load, and active reports a nonzero count.
module ldu_timer #(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  output logic active
);

  localparam int unsigned CNT_W = $clog2(LOAD_LAT) + 1;

  logic [CNT_W-1:0] ld_cnt_q;
  logic [CNT_W-1:0] ld_cnt_d;

  // Next count: clear, restart (no accumulation) or count down to zero
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    if (clr) begin
      ld_cnt_d = '0;
    end else if (load) begin
      ld_cnt_d = CNT_W'(LOAD_LAT - 1);
    end else if (ld_cnt_q != '0) begin
      ld_cnt_d = ld_cnt_q - CNT_W'(1);
    end
  end

  // Counter register, discarded immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
    end
  end

  assign active = (ld_cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-stage stall bus with bubble insertion,
// multi-cycle load-use hold and flush deferred until stages above
// FLUSH_IDX have drained. Optional performance counters are built when
// PIPE_CTRL_PERF_EN is defined; otherwise both counter ports read 0.
module pipe_ctrl
  import pipe_pkg::redirect_t;
#(
  parameter int unsigned STAGES    = pipe_pkg::STALL_BUS_W,
  parameter int unsigned ID_IDX    = pipe_pkg::ID_IDX,
  parameter int unsigned FLUSH_IDX = pipe_pkg::EX_IDX,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned PC_W      = pipe_pkg::PC_W
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int unsigned PKG_PC_W = pipe_pkg::PC_W;

  logic              flush_q;
  logic              flush_d;
  logic [PC_W-1:0]   new_pc_q;
  logic [PC_W-1:0]   new_pc_d;
  redirect_t         pend_q;
  redirect_t         pend_d;

  logic              ld_active;
  logic              drain_ok;
  logic [STAGES-1:0] req;
  logic [STAGES-1:0] stall_c;
  logic [STAGES-1:0] bubble_c;

  // Flush in flight (being scheduled or on the bus) wipes the timer;
  // a load_use seen during the flush cycle is dropped.
  ldu_timer #(
    .LOAD_LAT (LOAD_LAT)
  ) u_ldu_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (bus.load_use & ~flush_q),
    .clr    (flush_d | flush_q),
    .active (ld_active)
  );

  // Stall every stage up to the highest requester, bubble the one above it
  always_comb begin
    req = bus.stallreq;
    if (bus.load_use || ld_active) begin
      req[ID_IDX] = 1'b1;
    end
    stall_c = '0;
    if (!flush_q) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (req[i]) begin
          stall_c = {STAGES{1'b1}} >> (STAGES - 1 - i);
        end
      end
    end
    bubble_c = (stall_c << 1) & ~stall_c;
  end

  // Stages above the flushing stage must be free of stall requests
  always_comb begin
    drain_ok = 1'b1;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (i > FLUSH_IDX && bus.stallreq[i]) begin
        drain_ok = 1'b0;
      end
    end
  end

  // Flush scheduling: a pending request always wins over a new one
  always_comb begin
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    pend_d   = pend_q;
    if (pend_q.valid) begin
      if (drain_ok) begin
        flush_d      = 1'b1;
        new_pc_d     = PC_W'(pend_q.pc);
        pend_d.valid = 1'b0;
      end
    end else if (bus.flush_req) begin
      if (drain_ok) begin
        flush_d  = 1'b1;
        new_pc_d = bus.flush_pc;
      end else begin
        pend_d.valid = 1'b1;
        pend_d.pc    = PKG_PC_W'(bus.flush_pc);
      end
    end
  end

  // Flush pulse, redirect PC and pending request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      pend_q   <= '0;
    end else begin
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.stall  = stall_c;
  assign bus.bubble = bubble_c;
  assign bus.flush  = flush_q;
  assign bus.new_pc = new_pc_q;
  assign bus.busy   = pend_q.valid | ld_active;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt_q;
  logic [31:0] perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q;
  logic [31:0] perf_flush_cnt_d;

  // Free-running event counters, wrapping at 2^32
  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q + 32'(stall_c[0]);
    perf_flush_cnt_d = perf_flush_cnt_q + 32'(flush_q);
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_cnt_q;
  assign bus.perf_flush_cnt = perf_flush_cnt_q;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (STAGES=6, ID_IDX=2, FLUSH_IDX=3,
// LOAD_LAT=3): directed scenarios plus a randomized run against a
// cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_ctrl_if #(.STAGES(6), .PC_W(32)) bus ();

  pipe_ctrl #(
    .STAGES    (6),
    .ID_IDX    (2),
    .FLUSH_IDX (3),
    .LOAD_LAT  (LAT),
    .PC_W      (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Called just after a falling edge; inputs settle before sampling.
  task automatic drive(input logic [5:0] sr, input logic lu, input logic fr,
                       input logic [31:0] pc);
    bus.stallreq  = sr;
    bus.load_use  = lu;
    bus.flush_req = fr;
    bus.flush_pc  = pc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL reset_stall: got %b want %b", bus.stall, 6'b0); end
    n_checks++; if (bus.bubble !== 6'b0) begin n_fail++; $display("FAIL reset_bubble: got %b want %b", bus.bubble, 6'b0); end
    n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
    n_checks++; if (bus.new_pc !== 32'h0) begin n_fail++; $display("FAIL reset_new_pc: got %h want 0", bus.new_pc); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.perf_stall_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_perf_stall: got %0d want 0", bus.perf_stall_cnt); end
    n_checks++; if (bus.perf_flush_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_perf_flush: got %0d want 0", bus.perf_flush_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stall_encode();
    logic [5:0] sr_t [5] = '{6'b001000, 6'b100000, 6'b000001, 6'b010100, 6'b000000};
    logic [5:0] st_t [5] = '{6'b001111, 6'b111111, 6'b000001, 6'b011111, 6'b000000};
    logic [5:0] bb_t [5] = '{6'b010000, 6'b000000, 6'b000010, 6'b100000, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      drive(sr_t[i], 1'b0, 1'b0, 32'h0);
      n_checks++; if (bus.stall !== st_t[i]) begin n_fail++; $display("FAIL encode_stall[%0d]: got %b want %b", i, bus.stall, st_t[i]); end
      n_checks++; if (bus.bubble !== bb_t[i]) begin n_fail++; $display("FAIL encode_bubble[%0d]: got %b want %b", i, bus.bubble, bb_t[i]); end
      n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL encode_flush[%0d]: got %b want 0", i, bus.flush); end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    logic       lu_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [5:0] st_t [4] = '{6'b000111, 6'b000111, 6'b000111, 6'b000000};
    logic [5:0] bb_t [4] = '{6'b001000, 6'b001000, 6'b001000, 6'b000000};
    logic       by_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(6'b0, lu_t[i], 1'b0, 32'h0);
      n_checks++; if (bus.stall !== st_t[i]) begin n_fail++; $display("FAIL lu_stall[%0d]: got %b want %b", i, bus.stall, st_t[i]); end
      n_checks++; if (bus.bubble !== bb_t[i]) begin n_fail++; $display("FAIL lu_bubble[%0d]: got %b want %b", i, bus.bubble, bb_t[i]); end
      n_checks++; if (bus.busy !== by_t[i]) begin n_fail++; $display("FAIL lu_busy[%0d]: got %b want %b", i, bus.busy, by_t[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    drive(6'b0, 1'b0, 1'b1, 32'hBFC00380);
    n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL flush_c0_flush: got %b want 0", bus.flush); end
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL flush_c0_stall: got %b want 0", bus.stall); end
    @(negedge clk);
    // stall request and load_use during the flush cycle must be overridden
    drive(6'b001000, 1'b1, 1'b0, 32'h0);
    n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL flush_c1_flush: got %b want 1", bus.flush); end
    n_checks++; if (bus.new_pc !== 32'hBFC00380) begin n_fail++; $display("FAIL flush_c1_new_pc: got %h want bfc00380", bus.new_pc); end
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL flush_c1_stall: got %b want 0", bus.stall); end
    n_checks++; if (bus.bubble !== 6'b0) begin n_fail++; $display("FAIL flush_c1_bubble: got %b want 0", bus.bubble); end
    @(negedge clk);
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL flush_c2_flush: got %b want 0", bus.flush); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_c2_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL flush_c2_stall: got %b want 0", bus.stall); end
    n_checks++; if (bus.new_pc !== 32'hBFC00380) begin n_fail++; $display("FAIL flush_c2_new_pc: got %h want bfc00380", bus.new_pc); end
    @(negedge clk);
  endtask

  task automatic test_deferred_flush();
    logic [5:0]  sr_t [7] = '{6'b010000, 6'b010000, 6'b010000, 6'b010000, 6'b0, 6'b0, 6'b0};
    logic        fr_t [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] pc_t [7] = '{32'h80000180, 32'h0, 32'h1234, 32'h0, 32'h5555, 32'h0, 32'h0};
    logic        fl_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        by_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0]  st_t [7] = '{6'b011111, 6'b011111, 6'b011111, 6'b011111, 6'b0, 6'b0, 6'b0};
    for (int i = 0; i < 7; i++) begin
      drive(sr_t[i], 1'b0, fr_t[i], pc_t[i]);
      n_checks++; if (bus.flush !== fl_t[i]) begin n_fail++; $display("FAIL defer_flush[%0d]: got %b want %b", i, bus.flush, fl_t[i]); end
      n_checks++; if (bus.busy !== by_t[i]) begin n_fail++; $display("FAIL defer_busy[%0d]: got %b want %b", i, bus.busy, by_t[i]); end
      n_checks++; if (bus.stall !== st_t[i]) begin n_fail++; $display("FAIL defer_stall[%0d]: got %b want %b", i, bus.stall, st_t[i]); end
      if (i >= 5) begin
        n_checks++; if (bus.new_pc !== 32'h80000180) begin n_fail++; $display("FAIL defer_new_pc[%0d]: got %h want 80000180", i, bus.new_pc); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use_flush();
    drive(6'b0, 1'b1, 1'b1, 32'h00400000);
    n_checks++; if (bus.stall !== 6'b000111) begin n_fail++; $display("FAIL luf_c0_stall: got %b want 000111", bus.stall); end
    n_checks++; if (bus.bubble !== 6'b001000) begin n_fail++; $display("FAIL luf_c0_bubble: got %b want 001000", bus.bubble); end
    n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL luf_c0_flush: got %b want 0", bus.flush); end
    @(negedge clk);
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL luf_c1_flush: got %b want 1", bus.flush); end
    n_checks++; if (bus.new_pc !== 32'h00400000) begin n_fail++; $display("FAIL luf_c1_new_pc: got %h want 00400000", bus.new_pc); end
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL luf_c1_stall: got %b want 0", bus.stall); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL luf_c1_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL luf_c2_stall: got %b want 0", bus.stall); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL luf_c2_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL luf_c2_flush: got %b want 0", bus.flush); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(6'b010000, 1'b1, 1'b1, 32'hDEAD0000);
    @(negedge clk);
    drive(6'b010000, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", bus.stall); end
    n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rstmid_flush: got %b want 0", bus.flush); end
    n_checks++; if (bus.new_pc !== 32'h0) begin n_fail++; $display("FAIL rstmid_new_pc: got %h want 0", bus.new_pc); end
    n_checks++; if (bus.perf_stall_cnt !== 32'h0) begin n_fail++; $display("FAIL rstmid_perf_stall: got %0d want 0", bus.perf_stall_cnt); end
    n_checks++; if (bus.perf_flush_cnt !== 32'h0) begin n_fail++; $display("FAIL rstmid_perf_flush: got %0d want 0", bus.perf_flush_cnt); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(6'b0, 1'b0, 1'b0, 32'h0);
      n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_flush[%0d]: got %b want 0", i, bus.flush); end
      n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL rstmid_after_stall[%0d]: got %b want 0", i, bus.stall); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_busy[%0d]: got %b want 0", i, bus.busy); end
      @(negedge clk);
    end
  endtask

  // Model state starts from the clean post-reset condition left by test_reset_mid.
  task automatic test_random();
    int unsigned hold = 0;
    bit          fnow = 1'b0;
    logic [31:0] mpc  = 32'h0;
    logic [31:0] pq [$];
    int unsigned cs = 0;
    int unsigned cf = 0;
    logic [5:0]  sr, req, es, eb;
    logic        lu, fr, ebusy, drain, fire;
    logic [31:0] pc, exp_ps, exp_pf;
    int          k;
    for (int n = 0; n < 400; n++) begin
      sr = '0;
      for (int b = 0; b < 6; b++) sr[b] = ($urandom_range(3) == 0);
      lu = ($urandom_range(4) == 0);
      fr = ($urandom_range(5) == 0);
      pc = $urandom;
      req = sr | ((lu || hold > 0) ? 6'b000100 : 6'b000000);
      es = '0;
      eb = '0;
      if (!fnow && req != 0) begin
        k = 0;
        for (int b = 0; b < 6; b++) if (req[b]) k = b;
        es = 6'((1 << (k + 1)) - 1);
        eb = (k < 5) ? 6'(1 << (k + 1)) : 6'b0;
      end
      ebusy = (pq.size() != 0) || (hold != 0);
`ifdef PIPE_CTRL_PERF_EN
      exp_ps = cs;
      exp_pf = cf;
`else
      exp_ps = 32'h0;
      exp_pf = 32'h0;
`endif
      drive(sr, lu, fr, pc);
      n_checks++; if (bus.stall !== es) begin n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", n, bus.stall, es); end
      n_checks++; if (bus.bubble !== eb) begin n_fail++; $display("FAIL rand_bubble[%0d]: got %b want %b", n, bus.bubble, eb); end
      n_checks++; if (bus.flush !== fnow) begin n_fail++; $display("FAIL rand_flush[%0d]: got %b want %b", n, bus.flush, fnow); end
      n_checks++; if (bus.new_pc !== mpc) begin n_fail++; $display("FAIL rand_new_pc[%0d]: got %h want %h", n, bus.new_pc, mpc); end
      n_checks++; if (bus.busy !== ebusy) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b want %b", n, bus.busy, ebusy); end
      n_checks++; if (bus.perf_stall_cnt !== exp_ps) begin n_fail++; $display("FAIL rand_perf_stall[%0d]: got %0d want %0d", n, bus.perf_stall_cnt, exp_ps); end
      n_checks++; if (bus.perf_flush_cnt !== exp_pf) begin n_fail++; $display("FAIL rand_perf_flush[%0d]: got %0d want %0d", n, bus.perf_flush_cnt, exp_pf); end
      drain = ((sr >> 4) == 0);
      fire  = 1'b0;
      if (pq.size() != 0) begin
        if (drain) begin
          fire = 1'b1;
          mpc  = pq.pop_front();
        end
      end else if (fr) begin
        if (drain) begin
          fire = 1'b1;
          mpc  = pc;
        end else begin
          pq.push_back(pc);
        end
      end
      cs += es[0];
      cf += fnow;
      if (fire || fnow) hold = 0;
      else if (lu)      hold = LAT - 1;
      else if (hold > 0) hold--;
      fnow = fire;
      @(negedge clk);
    end
    drive(6'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #1;
    test_reset();
    test_stall_encode();
    test_load_use();
    test_flush();
    test_deferred_flush();
    test_load_use_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the MIPS core. Successor to the fixed 6-bit stall controller.
- Takes per-stage stall requests, an ID-stage load-use pulse and an exception/redirect flush request.
- Produces the per-stage stall bus, the bubble-insert vector, and a registered flush pulse with redirect PC to IF.
- Adds two things the old controller lacks: a multi-cycle load-use timer, and deferred flush while downstream stages are stalled.

Parameters:
- STAGES, 6: number of pipeline stages. Index 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
- ID_IDX, 2: stage index that raises load_use.
- FLUSH_IDX, 3: stage that raises flush_req. Stages above it must drain before the flush fires.
- LOAD_LAT, 1: number of cycles ID is held per load_use pulse (≥1).
- PC_W, 32: redirect PC width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- stallreq  in  STAGES  level stall request per stage (bit i from stage i)
- load_use  in  1  one-cycle pulse from ID: load-use hazard detected
- flush_req  in  1  one-cycle pulse: exception/redirect request
- flush_pc  in  PC_W  redirect target, valid with flush_req
- stall  out  STAGES  bit i=1: stage i holds its register
- bubble  out  STAGES  bit i=1: stage i loads a NOP this cycle
- flush  out  1  registered one-cycle flush pulse to all stages
- new_pc  out  PC_W  registered redirect PC, valid while flush=1
- busy  out  1  load-use timer running or flush pending
- perf_stall_cnt  out  32  see Optional Feature
- perf_flush_cnt  out  32  see Optional Feature

Behaviour:
- Reset: ld_cnt=0, pend=0, pend_pc=0, flush=0, new_pc=0. Combinational outputs settle to stall=0, bubble=0, busy=0.
- Effective request vector: r = stallreq, with bit ID_IDX also set when (load_use | ld_cnt!=0).
- k = highest index with r[k]=1.
  - stall[j]=1 for all j≤k; stall[j]=0 for j>k.
  - bubble[k+1]=1 if k+1<STAGES; all other bubble bits 0.
  - If r==0: stall=0, bubble=0.
- Load-use timer (down counter, width clog2(LOAD_LAT)+1):
  - load_use at cycle t loads ld_cnt=LOAD_LAT-1.
  - ID is therefore held cycles t..t+LOAD_LAT-1.
  - ld_cnt decrements each cycle while nonzero.
  - load_use while ld_cnt!=0: reload to LOAD_LAT-1. Restart, no accumulation.
- Flush:
  - drain_ok = (stallreq[STAGES-1:FLUSH_IDX+1]==0).
  - flush_req with drain_ok at cycle t: flush=1, new_pc=flush_pc at t+1.
  - flush_req without drain_ok: pend=1, pend_pc=flush_pc. In the first cycle drain_ok holds, schedule flush=1, new_pc=pend_pc for the next cycle and clear pend.
  - flush_req while pend=1, or in the cycle flush is being scheduled: ignored. The oldest request wins.
  - flush is high for exactly one cycle. new_pc holds its value afterwards; it is only meaningful while flush=1.
  - While flush=1: stall=0, bubble=0 (flush overrides), and ld_cnt cleared. load_use arriving in that cycle is ignored.
- busy = pend | (ld_cnt!=0).
- rst mid-operation: pending flush and timer discarded immediately (asynchronous).
- All outputs except flush/new_pc are combinational from inputs plus state. No path from flush_req to stall within the same cycle.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle stall[0]=1.
  - perf_flush_cnt increments each cycle flush=1.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports driven constant 0 and no counter flops are generated.

Decomposition:
- Shared package pipe_pkg holds:
  - stage index constants (PC_IDX..WB_IDX)
  - STALL_BUS_W
  - PC_W
  - the redirect-request struct {valid, pc}
- One sub-module: ldu_timer. It owns the load-use down counter: inputs load, clr, LOAD_LAT; output active.
- Priority encode and drain check stay inline.

Test Plan:
- STAGES=6, stallreq=6'b001000 (EX) -> stall=6'b001111, bubble=6'b010000, flush=0.
- LOAD_LAT=3, load_use pulse at cycle 10, no other requests -> stall=6'b000111 for cycles 10,11,12; bubble=6'b001000 those cycles; stall=0 at cycle 13; busy=1 in cycles 11,12.
- flush_req at cycle 5 with flush_pc=0xBFC00380 and stallreq=0 -> flush=1, new_pc=0xBFC00380 at cycle 6 only; stall=0 in cycle 6.
- stallreq[4] (MEM) held cycles 5-8, flush_req at 5 (pc=0x80000180), second flush_req at 7 (pc=0x1234) -> pend=1 cycles 6-9; flush=1, new_pc=0x80000180 at cycle 10; second request ignored.
- LOAD_LAT=3, load_use at 20, flush_req at 20 -> flush at 21; ld_cnt cleared at 21; stall=0 at 21 and 22.
- Assert rst at cycle 3 while pend=1 and ld_cnt=2 -> all state 0 immediately; no flush after release. With PIPE_CTRL_PERF_EN defined, counters read 0.
